// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Opcode, funct and ALU-control constants for the MIPS decode
//                stage, the decoded-operation record and the decode function.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_SLTIU = 6'b001011;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_XORI  = 6'b001110;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;

  // R-type funct field
  localparam logic [5:0] c_FN_SLL  = 6'b000000;
  localparam logic [5:0] c_FN_SRL  = 6'b000010;
  localparam logic [5:0] c_FN_SRA  = 6'b000011;
  localparam logic [5:0] c_FN_SLLV = 6'b000100;
  localparam logic [5:0] c_FN_SRLV = 6'b000110;
  localparam logic [5:0] c_FN_SRAV = 6'b000111;
  localparam logic [5:0] c_FN_JR   = 6'b001000;
  localparam logic [5:0] c_FN_ADD  = 6'b100000;
  localparam logic [5:0] c_FN_ADDU = 6'b100001;
  localparam logic [5:0] c_FN_SUB  = 6'b100010;
  localparam logic [5:0] c_FN_SUBU = 6'b100011;
  localparam logic [5:0] c_FN_AND  = 6'b100100;
  localparam logic [5:0] c_FN_OR   = 6'b100101;
  localparam logic [5:0] c_FN_XOR  = 6'b100110;
  localparam logic [5:0] c_FN_NOR  = 6'b100111;
  localparam logic [5:0] c_FN_SLT  = 6'b101010;
  localparam logic [5:0] c_FN_SLTU = 6'b101011;

  // ALU control codes (R-type codes reuse the funct encoding)
  localparam logic [5:0] c_ALUC_ADD  = 6'b100000;
  localparam logic [5:0] c_ALUC_ADDU = 6'b100001;
  localparam logic [5:0] c_ALUC_SUB  = 6'b100010;
  localparam logic [5:0] c_ALUC_SUBU = 6'b100011;
  localparam logic [5:0] c_ALUC_AND  = 6'b100100;
  localparam logic [5:0] c_ALUC_OR   = 6'b100101;
  localparam logic [5:0] c_ALUC_XOR  = 6'b100110;
  localparam logic [5:0] c_ALUC_NOR  = 6'b100111;
  localparam logic [5:0] c_ALUC_SLT  = 6'b101010;
  localparam logic [5:0] c_ALUC_SLTU = 6'b101011;
  localparam logic [5:0] c_ALUC_SLL  = 6'b000000;
  localparam logic [5:0] c_ALUC_SRL  = 6'b000010;
  localparam logic [5:0] c_ALUC_SRA  = 6'b000011;
  localparam logic [5:0] c_ALUC_SLLV = 6'b000100;
  localparam logic [5:0] c_ALUC_SRLV = 6'b000110;
  localparam logic [5:0] c_ALUC_SRAV = 6'b000111;
  localparam logic [5:0] c_ALUC_LUI  = 6'b001111;

  // One decoded operation; legal=0 means the word is not supported
  typedef struct packed {
    logic        legal;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  aluc;
    logic [4:0]  rd;
    logic        we;
  } dec_op_t;

  // Pure combinational decode of one instruction word and its source values
  function automatic dec_op_t decode(input logic [31:0] instr,
                                     input logic [31:0] rs_val,
                                     input logic [31:0] rt_val);
    dec_op_t     d;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] sext;
    logic [31:0] zext;
    op   = instr[31:26];
    fn   = instr[5:0];
    sext = {{16{instr[15]}}, instr[15:0]};
    zext = {16'b0, instr[15:0]};
    d    = '0;
    case (op)
      c_OP_RTYPE: begin
        d.a    = rs_val;
        d.b    = rt_val;
        d.aluc = fn;
        d.rd   = instr[15:11];
        d.we   = 1'b1;
        case (fn)
          c_FN_ADD, c_FN_ADDU, c_FN_SUB, c_FN_SUBU, c_FN_AND,
          c_FN_OR, c_FN_XOR, c_FN_NOR, c_FN_SLT, c_FN_SLTU,
          c_FN_SLLV, c_FN_SRLV, c_FN_SRAV: d.legal = 1'b1;
          c_FN_SLL, c_FN_SRL, c_FN_SRA: begin
            // Fixed shifts carry the shift amount in operand a
            d.legal = 1'b1;
            d.a     = {27'b0, instr[10:6]};
          end
          default: d = '0;  // includes JR
        endcase
      end
      c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU,
      c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
        d.legal = 1'b1;
        d.a     = rs_val;
        d.rd    = instr[20:16];
        d.we    = 1'b1;
        case (op)
          c_OP_ADDI:  begin d.aluc = c_ALUC_ADD;  d.b = sext; end
          c_OP_ADDIU: begin d.aluc = c_ALUC_ADDU; d.b = sext; end
          c_OP_SLTI:  begin d.aluc = c_ALUC_SLT;  d.b = sext; end
          c_OP_SLTIU: begin d.aluc = c_ALUC_SLTU; d.b = sext; end
          c_OP_ANDI:  begin d.aluc = c_ALUC_AND;  d.b = zext; end
          c_OP_ORI:   begin d.aluc = c_ALUC_OR;   d.b = zext; end
          default:    begin d.aluc = c_ALUC_XOR;  d.b = zext; end
        endcase
      end
      c_OP_LUI: begin
        d.legal = 1'b1;
        d.aluc  = c_ALUC_LUI;
        d.a     = zext;
        d.b     = '0;
        d.rd    = instr[20:16];
        d.we    = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w
//  Description : 32x32 register file, two asynchronous read ports, one
//                synchronous write port, r0 hardwired to zero.
//                RF_CLEAR=1 clears every register on reset.
//                Macro ID_WB_BYPASS_EN: reads of the register being written
//                return the write data in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
  parameter int RF_CLEAR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_raddr1,
  output logic [31:0] o_rdata1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_mem [0:31];
  logic        w_wr;

  // Writes to r0 are dropped here so r0 never holds anything but zero
  assign w_wr = i_we && (i_waddr != 5'd0);

  generate
    if (RF_CLEAR != 0) begin : g_rf_clear
      // Storage with full asynchronous clear
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < 32; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
          r_mem[i_waddr] <= i_wdata;
        end
      end
    end else begin : g_rf_noclear
      // Storage left unreset; a write coinciding with reset is still dropped
      always_ff @(posedge clk) begin
        if (!rst && w_wr) r_mem[i_waddr] <= i_wdata;
      end
    end
  endgenerate

`ifdef ID_WB_BYPASS_EN
  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 :
                    (w_wr && (i_waddr == i_raddr1)) ? i_wdata : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 :
                    (w_wr && (i_waddr == i_raddr2)) ? i_wdata : r_mem[i_raddr2];
`else
  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_mem[i_raddr2];
`endif

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : MIPS instruction-decode stage. Reads the register file,
//                decodes ALU ops and presents them one cycle later through a
//                valid/ready output register. Unsupported words are consumed
//                and flagged with a one-cycle illegal pulse.
//                Macro ID_WB_BYPASS_EN enables writeback-to-read bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage
  import mips_pkg::*;
#(
  parameter int RF_CLEAR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [5:0]  out_aluc,
  output logic [4:0]  out_rd,
  output logic        out_we,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        illegal
);

  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  dec_op_t     w_dec;
  logic        w_xfer;

  logic        r_out_valid;
  logic        r_illegal;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [5:0]  r_aluc;
  logic [4:0]  r_rd;
  logic        r_we;

  regfile_2r1w #(
    .RF_CLEAR (RF_CLEAR)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .i_raddr1 (in_instr[25:21]),
    .o_rdata1 (w_rs_val),
    .i_raddr2 (in_instr[20:16]),
    .o_rdata2 (w_rt_val),
    .i_we     (wb_we),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data)
  );

  // The output register can take a new word when empty or being drained
  assign in_ready = !r_out_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;
  assign w_dec    = decode(in_instr, w_rs_val, w_rt_val);

  // Output register: load on a legal transfer, hold while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_aluc      <= '0;
      r_rd        <= '0;
      r_we        <= 1'b0;
    end else begin
      r_illegal <= w_xfer && !w_dec.legal;
      if (w_xfer && w_dec.legal) begin
        r_out_valid <= 1'b1;
        r_a         <= w_dec.a;
        r_b         <= w_dec.b;
        r_aluc      <= w_dec.aluc;
        r_rd        <= w_dec.rd;
        r_we        <= w_dec.we;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign illegal   = r_illegal;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_aluc  = r_aluc;
  assign out_rd    = r_rd;
  assign out_we    = r_we;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Scoreboard bench for id_stage. Stimulus pushes the expected
//                decoded op (or an illegal marker) when a word is accepted;
//                a monitor on the falling edge compares and pops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

  typedef struct {
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  aluc;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [5:0]  out_aluc;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  id_stage #(.RF_CLEAR(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_aluc  (out_aluc),
    .out_rd    (out_rd),
    .out_we    (out_we),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [5:0] aluc, input logic [4:0] rd);
    exp_t e;
    e.ill = 1'b0; e.a = a; e.b = b; e.aluc = aluc; e.rd = rd; e.we = 1'b1;
    return e;
  endfunction

  function automatic exp_t mk_ill();
    exp_t e;
    e.ill = 1'b1; e.a = '0; e.b = '0; e.aluc = '0; e.rd = '0; e.we = 1'b0;
    return e;
  endfunction

  // Present a word until accepted; expectation is queued at acceptance
  task automatic send(input logic [31:0] instr, input exp_t e);
    logic acc;
    int   waited;
    acc = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_instr = instr;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back(e);
      @(posedge clk); #1;
      waited++;
      if (!acc && waited > 50) begin
        n_tests++; n_fail++;
        $display("FAIL send timeout: in_ready=%b required 1", in_ready);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wb_we = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge clk); #1;
    wb_we = 1'b0;
  endtask

  // Monitor: compare presented ops and illegal pulses against the queue
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0 || sb[0].ill) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected op: out_valid=1 rd=%0d required no op", out_rd);
        end else begin
          chk("op.a", out_a, sb[0].a);
          chk("op.b", out_b, sb[0].b);
          chk("op.aluc", {26'b0, out_aluc}, {26'b0, sb[0].aluc});
          chk("op.rd", {27'b0, out_rd}, {27'b0, sb[0].rd});
          chk("op.we", {31'b0, out_we}, {31'b0, sb[0].we});
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (illegal) begin
        n_tests++;
        if (sb.size() == 0 || !sb[0].ill) begin
          n_fail++;
          $display("FAIL unexpected illegal: illegal=1 required 0");
        end else begin
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst illegal", {31'b0, illegal}, 32'd0);
    chk("rst out_a", out_a, 32'd0);
    chk("rst out_b", out_b, 32'd0);
    chk("rst aluc/rd/we", {20'b0, out_aluc, out_rd, out_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // ORI r1,r0,0x1234
    send(32'h34011234, mk(32'h0, 32'h00001234, 6'b100101, 5'd1));
    wb(5'd2, 32'h80000000);
    // ADDI r3,r2,-1
    send(32'h2043FFFF, mk(32'h80000000, 32'hFFFFFFFF, 6'b100000, 5'd3));
    wb(5'd5, 32'hF0000000);
    // SRA r4,r5,7
    send(32'h000521C3, mk(32'h7, 32'hF0000000, 6'b000011, 5'd4));
    // LUI r8,0xABCD
    send(32'h3C08ABCD, mk(32'h0000ABCD, 32'h0, 6'b001111, 5'd8));
    // SLTIU r9,r2,0x8000 (sign-extended immediate)
    send(32'h2C498000, mk(32'h80000000, 32'hFFFF8000, 6'b101011, 5'd9));
    // NOR r10,r2,r5
    send(32'h00455027, mk(32'h80000000, 32'hF0000000, 6'b100111, 5'd10));
    // SLLV r11,r5,r2
    send(32'h00455804, mk(32'h80000000, 32'hF0000000, 6'b000100, 5'd11));
    // JR r31: one-cycle illegal pulse, no op
    send(32'h03E00008, mk_ill());
    @(negedge clk);
    chk("jr out_valid", {31'b0, out_valid}, 32'd0);
    chk("jr illegal", {31'b0, illegal}, 32'd1);
    @(negedge clk);
    chk("jr pulse width", {31'b0, illegal}, 32'd0);
    @(posedge clk); #1;

    // Backpressure: A stalls, B waits, nothing lost
    out_ready = 1'b0;
    send(32'h34011234, mk(32'h0, 32'h00001234, 6'b100101, 5'd1));
    fork
      send(32'h384C00FF, mk(32'h80000000, 32'h000000FF, 6'b100110, 5'd12));
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join

    // Writeback to r6 in the same cycle as ADDU r7,r6,r0
    wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000DEAD;
`ifdef ID_WB_BYPASS_EN
    send(32'h00C03821, mk(32'h0000DEAD, 32'h0, 6'b100001, 5'd7));
`else
    send(32'h00C03821, mk(32'h0, 32'h0, 6'b100001, 5'd7));
`endif
    wb_we = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset during a stall with a coincident writeback
    out_ready = 1'b0;
    send(32'h34011234, mk(32'h0, 32'h00001234, 6'b100101, 5'd1));
    @(posedge clk); #1;
    rst = 1'b1; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h00005555;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    // ADDU r14,r9,r2: both cleared by reset, write to r9 lost
    send(32'h01227021, mk(32'h0, 32'h0, 6'b100001, 5'd14));

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
